// File: rtl/multi_channel_square_wave_generator_if.sv
// Bus bundle for the multi-channel square-wave generator. The period_done_o pulses exist
// only when SQW_PERIOD_DONE_EN is defined.
interface multi_channel_square_wave_generator_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DUTY_W = 4
);
  logic [NUM_CH-1:0]        en_i;
  logic [NUM_CH-1:0]        load_i;
  logic [NUM_CH*DUTY_W-1:0] on_duty_i;
  logic [NUM_CH*DUTY_W-1:0] off_duty_i;
  logic [NUM_CH-1:0]        wave_o;
`ifdef SQW_PERIOD_DONE_EN
  logic [NUM_CH-1:0]        period_done_o;

  modport master (
    output en_i, load_i, on_duty_i, off_duty_i,
    input  wave_o, period_done_o
  );

  modport slave (
    input  en_i, load_i, on_duty_i, off_duty_i,
    output wave_o, period_done_o
  );
`else
  modport master (
    output en_i, load_i, on_duty_i, off_duty_i,
    input  wave_o
  );

  modport slave (
    input  en_i, load_i, on_duty_i, off_duty_i,
    output wave_o
  );
`endif
endinterface

// File: rtl/multi_channel_square_wave_generator.sv
// Independent per-channel square-wave generators with shadowed on/off duty registers.
// Optional SQW_PERIOD_DONE_EN adds a registered one-cycle pulse per period boundary.
module multi_channel_square_wave_generator #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DUTY_W      = 4,
  parameter int unsigned TICK_CYCLES = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  multi_channel_square_wave_generator_if.slave sqw
);

  localparam int unsigned MaxTicks = TICK_CYCLES * ((2 ** DUTY_W) - 1);
  localparam int unsigned CntW     = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
  // One spare bit so TICK_CYCLES*duty never wraps before the -1.
  localparam int unsigned ProdW    = CntW + 1;
  localparam logic [ProdW-1:0] Tick = ProdW'(TICK_CYCLES);

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DUTY_W-1:0]   sh_on_q, sh_off_q, sh_on_d, sh_off_d;
    logic [DUTY_W-1:0]   act_on_q, act_off_q, act_on_d, act_off_d;
    logic [ProdW-1:0]    on_ticks, off_ticks;
    logic                on_end, off_end, boundary, start, reload;
    logic                wave_q;

    // Shadow next-state doubles as the reload source, giving load/boundary bypass.
    assign sh_on_d  = sqw.load_i[c] ? sqw.on_duty_i[c*DUTY_W +: DUTY_W]  : sh_on_q;
    assign sh_off_d = sqw.load_i[c] ? sqw.off_duty_i[c*DUTY_W +: DUTY_W] : sh_off_q;

    assign on_ticks  = Tick * ProdW'(act_on_q);
    assign off_ticks = Tick * ProdW'(act_off_q);
    assign on_end    = (cnt_q == CntW'(on_ticks - ProdW'(1)));
    assign off_end   = (cnt_q == CntW'(off_ticks - ProdW'(1)));

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      act_on_d  = act_on_q;
      act_off_d = act_off_q;
      boundary  = 1'b0;
      start     = 1'b0;
      if (!sqw.en_i[c]) begin
        state_d   = StIdle;
        cnt_d     = '0;
        act_on_d  = '0;
        act_off_d = '0;
      end else begin
        unique case (state_q)
          StIdle: start = 1'b1;
          StOn: begin
            if (on_end) begin
              cnt_d = '0;
              if (act_off_q != '0) state_d = StOff;
              else                 boundary = 1'b1;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
          StOff: begin
            if ((act_off_q == '0) || off_end) begin
              cnt_d    = '0;
              boundary = 1'b1;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
          default: state_d = StIdle;
        endcase
      end
      reload = boundary | start;
      if (reload) begin
        act_on_d  = sh_on_d;
        act_off_d = sh_off_d;
        state_d   = (sh_on_d != '0) ? StOn : StOff;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        sh_on_q   <= '0;
        sh_off_q  <= '0;
        act_on_q  <= '0;
        act_off_q <= '0;
        wave_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        sh_on_q   <= sh_on_d;
        sh_off_q  <= sh_off_d;
        act_on_q  <= act_on_d;
        act_off_q <= act_off_d;
        wave_q    <= (state_d == StOn);
      end
    end

    assign sqw.wave_o[c] = wave_q;

`ifdef SQW_PERIOD_DONE_EN
    logic pd_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) pd_q <= 1'b0;
      else         pd_q <= boundary;
    end

    assign sqw.period_done_o[c] = pd_q;
`endif
  end

endmodule

// File: tb/tb_multi_channel_square_wave_generator.sv
// Directed plus randomized bench; a position-in-period reference model predicts each channel.
module tb_multi_channel_square_wave_generator;
  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned DUTY_W      = 4;
  localparam int unsigned TICK_CYCLES = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_channel_square_wave_generator_if #(.NUM_CH(NUM_CH), .DUTY_W(DUTY_W)) sqw ();

  multi_channel_square_wave_generator #(
    .NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .TICK_CYCLES(TICK_CYCLES)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .sqw   (sqw)
  );

  int checks = 0;
  int errors = 0;

  // Model: each running channel sits at position m_t within a period of known length.
  int m_sh_on[NUM_CH], m_sh_off[NUM_CH], m_on[NUM_CH], m_off[NUM_CH], m_t[NUM_CH];
  bit m_run[NUM_CH];
  logic [NUM_CH-1:0] exp_wave = '0;
  logic [NUM_CH-1:0] exp_pd   = '0;

  function automatic int period_len(int c);
    int len;
    len = int'(TICK_CYCLES) * (m_on[c] + m_off[c]);
    return (len == 0) ? 1 : len;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_sh_on[c] = 0; m_sh_off[c] = 0; m_on[c] = 0; m_off[c] = 0; m_t[c] = 0; m_run[c] = 0;
    end
    exp_wave = '0;
    exp_pd   = '0;
  endtask

  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      int nsh_on, nsh_off, len;
      nsh_on  = sqw.load_i[c] ? int'(sqw.on_duty_i[c*DUTY_W +: DUTY_W])  : m_sh_on[c];
      nsh_off = sqw.load_i[c] ? int'(sqw.off_duty_i[c*DUTY_W +: DUTY_W]) : m_sh_off[c];
      exp_pd[c] = 1'b0;
      if (!sqw.en_i[c]) begin
        m_run[c] = 0; m_t[c] = 0; m_on[c] = 0; m_off[c] = 0;
      end else if (!m_run[c]) begin
        m_run[c] = 1; m_on[c] = nsh_on; m_off[c] = nsh_off; m_t[c] = 0;
      end else begin
        len    = period_len(c);
        m_t[c] = m_t[c] + 1;
        if (m_t[c] >= len) begin
          exp_pd[c] = 1'b1;
          m_on[c] = nsh_on; m_off[c] = nsh_off; m_t[c] = 0;
        end
      end
      m_sh_on[c]  = nsh_on;
      m_sh_off[c] = nsh_off;
      exp_wave[c] = m_run[c] && (m_t[c] < int'(TICK_CYCLES) * m_on[c]);
    end
  endtask

  task automatic check_outputs();
    checks++;
    assert (sqw.wave_o === exp_wave) else begin
      errors++;
      $error("FAIL wave t=%0t got %b exp %b", $time, sqw.wave_o, exp_wave);
    end
`ifdef SQW_PERIOD_DONE_EN
    checks++;
    assert (sqw.period_done_o === exp_pd) else begin
      errors++;
      $error("FAIL period_done t=%0t got %b exp %b", $time, sqw.period_done_o, exp_pd);
    end
`endif
  endtask

  // One clock: model tracks the edge, outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_duty(int c, int on, int off);
    sqw.on_duty_i[c*DUTY_W +: DUTY_W]  = DUTY_W'(on);
    sqw.off_duty_i[c*DUTY_W +: DUTY_W] = DUTY_W'(off);
  endtask

  task automatic pulse_load(int c, int on, int off);
    set_duty(c, on, off);
    sqw.load_i[c] = 1'b1;
    cycle();
    sqw.load_i[c] = 1'b0;
  endtask

  int  hi, lo;
  bit  found;

  initial begin
    sqw.en_i = '0; sqw.load_i = '0; sqw.on_duty_i = '0; sqw.off_duty_i = '0;
    model_reset();
    #3;
    checks++;
    assert (sqw.wave_o === '0) else begin
      errors++; $error("FAIL reset_wave got %b exp 0", sqw.wave_o);
    end
    run(3);
    #4 rst_n = 1'b1;
    run(2);

    // 3/2 on channel 0, load and enable on the same edge.
    set_duty(0, 3, 2);
    sqw.load_i[0] = 1'b1;
    sqw.en_i[0]   = 1'b1;
    cycle();
    sqw.load_i[0] = 1'b0;
    hi = 0;
    while (sqw.wave_o[0] && hi < 100) begin hi++; cycle(); end
    lo = 0;
    while (!sqw.wave_o[0] && lo < 100) begin lo++; cycle(); end
    checks++;
    assert (hi === 30) else begin errors++; $error("FAIL high_len got %0d exp 30", hi); end
    checks++;
    assert (lo === 20) else begin errors++; $error("FAIL low_len got %0d exp 20", lo); end
    run(60);

    // Mid-ON load of 1/1: current period completes first.
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (exp_wave[0] && m_t[0] == 5) begin found = 1; break; end
      cycle();
    end
    pulse_load(0, 1, 1);
    run(80);
    // Load coinciding exactly with the boundary edge.
    for (int i = 0; i < 200; i++) begin
      if (m_run[0] && m_t[0] + 1 == period_len(0)) begin found = found & 1'b1; break; end
      cycle();
    end
    checks++;
    assert (found && m_t[0] + 1 == period_len(0)) else begin
      errors++; $error("FAIL wait_boundary timeout got %0d exp %0d", m_t[0] + 1, period_len(0));
    end
    pulse_load(0, 2, 3);
    run(120);

    // Zero-duty corner cases on channels 1..3.
    set_duty(1, 0, 4); set_duty(2, 4, 0); set_duty(3, 0, 0);
    sqw.load_i[3:1] = 3'b111;
    sqw.en_i[3:1]   = 3'b111;
    cycle();
    sqw.load_i = '0;
    run(100);
    checks++;
    assert (sqw.wave_o[3:1] === 3'b010) else begin
      errors++; $error("FAIL zero_duty got %b exp 010", sqw.wave_o[3:1]);
    end

    // Four channels, staggered starts, then drop channel 1 mid-ON.
    sqw.en_i = '0;
    cycle();
    set_duty(0, 3, 2); set_duty(1, 2, 1); set_duty(2, 1, 4); set_duty(3, 5, 3);
    sqw.load_i = '1;
    cycle();
    sqw.load_i = '0;
    sqw.en_i[0] = 1'b1; run(3);
    sqw.en_i[1] = 1'b1; run(5);
    sqw.en_i[2] = 1'b1; run(7);
    sqw.en_i[3] = 1'b1; run(150);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (exp_wave[1] && m_t[1] == 4) begin found = 1; break; end
      cycle();
    end
    sqw.en_i[1] = 1'b0;
    cycle();
    checks++;
    assert (found && sqw.wave_o[1] === 1'b0) else begin
      errors++; $error("FAIL en_drop got %b exp 0 (found=%0d)", sqw.wave_o[1], found);
    end
    run(60);

    // Asynchronous reset pulse between edges while running.
    sqw.en_i = '1;
    run(17);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    assert (sqw.wave_o === '0) else begin
      errors++; $error("FAIL async_reset got %b exp 0", sqw.wave_o);
    end
    #1 rst_n = 1'b1;
    run(50);
    for (int c = 0; c < NUM_CH; c++) set_duty(c, 2, 2);
    sqw.load_i = '1;
    cycle();
    sqw.load_i = '0;
    run(100);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 199) == 0) sqw.en_i[c] = ~sqw.en_i[c];
        sqw.load_i[c] = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 3) == 0)
          set_duty(c, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        else
          set_duty(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_channel_square_wave_generator.md
MULTI_CHANNEL_SQUARE_WAVE_GENERATOR -- requirements
Module: multi_channel_square_wave_generator

Interface
REQ-001 Parameters SHALL be:
- NUM_CH, default 4: number of independent channels.
- DUTY_W, default 4: width of each on/off duty field.
- TICK_CYCLES, default 10: clock cycles per duty unit.
REQ-002 Ports SHALL be:
- clk_i  input  1  single clock; all state on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- en_i  input  NUM_CH  per-channel run enable.
- load_i  input  NUM_CH  per-channel strobe capturing duty inputs into the shadow registers.
- on_duty_i  input  NUM_CH*DUTY_W  on-time in duty units; channel c occupies bits [c*DUTY_W +: DUTY_W].
- off_duty_i  input  NUM_CH*DUTY_W  off-time in duty units; same packing.
- wave_o  output  NUM_CH  registered square-wave outputs.
- period_done_o  output  NUM_CH  present only with SQW_PERIOD_DONE_EN (REQ-020).

Function
REQ-003 Each channel SHALL be fully independent: its own shadow on/off registers, active on/off registers, cycle counter and 3-state FSM (IDLE, ON, OFF).
REQ-004 Counter width SHALL be sized to hold TICK_CYCLES*(2^DUTY_W-1)-1 without overflow, and products SHALL be computed at that width.
REQ-005 If load_i[c]=1 at an edge, shadow_on[c]/shadow_off[c] SHALL capture the channel's duty fields; otherwise they hold.
REQ-006 IDLE: wave_o[c]=0, counter=0; when en_i[c]=1, active SHALL be loaded from shadow and the FSM SHALL go to ON if active_on>0, else OFF.
REQ-007 ON: wave_o[c]=1; counter increments each cycle; at counter=TICK_CYCLES*active_on-1 the counter SHALL clear and the FSM SHALL go to OFF if active_off>0, else perform a period boundary and remain ON.
REQ-008 OFF: wave_o[c]=0; at counter=TICK_CYCLES*active_off-1 (or immediately when active_off=0) the counter SHALL clear and a period boundary SHALL occur.
REQ-009 Period boundary: active SHALL be reloaded from shadow and the next state SHALL be ON if the new active_on>0, else OFF.
REQ-010 Duty changes SHALL take effect only at a period boundary or on IDLE exit, never mid-phase.
REQ-011 If load_i[c] and a period boundary (or IDLE exit) coincide, the reload SHALL use the values being loaded that cycle (bypass).
REQ-012 on=0, off>0: output constantly 0, period TICK_CYCLES*off.
REQ-013 on>0, off=0: output constantly 1, period TICK_CYCLES*on.
REQ-014 on=0, off=0: output 0, with a period boundary every cycle.
REQ-015 en_i[c]=0 in any state SHALL force IDLE at the next edge; active values SHALL be discarded and shadow values retained.
REQ-016 wave_o[c] SHALL be a register equal to 1 exactly when the FSM is in ON; the first high cycle SHALL begin one edge after en_i[c] is sampled high.
REQ-017 With on=a and off=b (both >0), the waveform SHALL be exactly TICK_CYCLES*a cycles high, then TICK_CYCLES*b cycles low, repeating.

Reset
REQ-018 While rst_ni=0, all channels SHALL be in IDLE with counters=0, shadow/active=0, wave_o=0 and period_done_o=0, independent of clk_i.
REQ-019 Reset asserted mid-period SHALL abort immediately. After deassertion, a channel with en_i high SHALL start from IDLE using shadow=0 (constant low) until load_i is applied.

Configuration
REQ-020 With macro SQW_PERIOD_DONE_EN defined:
- period_done_o[c] SHALL be a registered one-cycle pulse for every period boundary of channel c, visible the cycle after the boundary edge.
- Continuous pulses SHALL occur in the on=0/off=0 case.
Without the macro, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-021 TICK_CYCLES=10, ch0 load on=3/off=2, en high -> wave_o[0] repeats 30 cycles high, 20 low; first high one edge after en sampled.
REQ-022 ch0 running 3/2; load 1/1 mid-ON -> current 30-high/20-low completes, then 10 high/10 low; load pulsed on the exact boundary cycle -> new values used immediately.
REQ-023 Channel zero-duty cases: on=0/off=4 -> constant 0; on=4/off=0 -> constant 1; 0/0 -> constant 0 and (macro on) period_done_o high every cycle.
REQ-024 Four channels with different duties, started on staggered cycles -> each matches REQ-017 independently; en_i[1] dropped mid-ON -> wave_o[1]=0 next edge, other channels unaffected.
REQ-025 rst_ni pulsed low between clock edges mid-period -> all wave_o=0 immediately; after release with en high and no load, outputs stay 0; load 2/2 -> 20/20 waveform resumes.
REQ-026 Macro on, ch0 2/3 -> period_done_o[0] single pulse every 50 cycles aligned to period start; macro off -> build without port passes REQ-021..025.
